// File: rtl/pkg_video_csc.sv
// Fixed-point colour-space constants and helpers shared by the forward and inverse converters.
// Coefficients are scaled by 256 (8 fractional bits).
package pkg_video_csc;

  localparam logic signed [19:0] COEF_R_CR = 20'sd359;
  localparam logic signed [19:0] COEF_G_CB = 20'sd88;
  localparam logic signed [19:0] COEF_G_CR = 20'sd183;
  localparam logic signed [19:0] COEF_B_CB = 20'sd454;
  localparam logic signed [19:0] ROUND_K   = 20'sd128;
  localparam logic signed [19:0] CHROMA_OFS = 20'sd128;

  function automatic logic [7:0] clamp_u8(input logic signed [11:0] v);
    if (v < 12'sd0) begin
      return 8'd0;
    end else if (v > 12'sd255) begin
      return 8'd255;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/image_ycbcr444_rgb888_if.sv
// Pixel stream bundle: YCbCr input side, RGB output side and the geometry error flag.
interface image_ycbcr444_rgb888_if;

  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_Y;
  logic [7:0] per_img_Cb;
  logic [7:0] per_img_Cr;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_red;
  logic [7:0] post_img_green;
  logic [7:0] post_img_blue;
  logic       size_err;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output per_img_Y, per_img_Cb, per_img_Cr,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_red, post_img_green, post_img_blue, size_err
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  per_img_Y, per_img_Cb, per_img_Cr,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_red, post_img_green, post_img_blue, size_err
  );

endinterface

// File: rtl/video_sync_delay.sv
// Shift register that delays the {vsync, href, clken} bundle by DEPTH clocks.
module video_sync_delay #(
  parameter int unsigned DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  logic [DEPTH-1:0][2:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], din};
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/image_ycbcr444_rgb888.sv
// YCbCr444 -> RGB888 converter with a fixed 3-clock pipeline and an input-side
// frame geometry checker.
module image_ycbcr444_rgb888
  import pkg_video_csc::*;
#(
  parameter logic [11:0] IMG_HDISP = 12'd640,
  parameter logic [11:0] IMG_VDISP = 12'd480
) (
  input logic                     clk,
  input logic                     rst,
  image_ycbcr444_rgb888_if.slave  vid
);

  logic signed [19:0] y_ext, cb_ext, cr_ext;
  logic signed [19:0] y_q, r_cr_q, g_cb_q, g_cr_q, b_cb_q;
  logic signed [19:0] r_sum_q, g_sum_q, b_sum_q;
  logic [7:0]         red_q, green_q, blue_q;
  logic [2:0]         sync_dly;

  assign y_ext  = $signed({4'b0000, vid.per_img_Y, 8'b0000_0000});
  assign cb_ext = $signed({12'b0, vid.per_img_Cb}) - CHROMA_OFS;
  assign cr_ext = $signed({12'b0, vid.per_img_Cr}) - CHROMA_OFS;

  // Free-running datapath; only the sync bundle qualifies which beats are real.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      r_cr_q  <= '0;
      g_cb_q  <= '0;
      g_cr_q  <= '0;
      b_cb_q  <= '0;
      r_sum_q <= '0;
      g_sum_q <= '0;
      b_sum_q <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      y_q     <= y_ext;
      r_cr_q  <= cr_ext * COEF_R_CR;
      g_cb_q  <= cb_ext * COEF_G_CB;
      g_cr_q  <= cr_ext * COEF_G_CR;
      b_cb_q  <= cb_ext * COEF_B_CB;
      r_sum_q <= y_q + r_cr_q + ROUND_K;
      g_sum_q <= y_q - g_cb_q - g_cr_q + ROUND_K;
      b_sum_q <= y_q + b_cb_q + ROUND_K;
      red_q   <= clamp_u8(r_sum_q[19:8]);
      green_q <= clamp_u8(g_sum_q[19:8]);
      blue_q  <= clamp_u8(b_sum_q[19:8]);
    end
  end

  video_sync_delay #(
    .DEPTH (3)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({vid.per_frame_vsync, vid.per_frame_href, vid.per_frame_clken}),
    .dout (sync_dly)
  );

  assign vid.post_frame_vsync = sync_dly[2];
  assign vid.post_frame_href  = sync_dly[1];
  assign vid.post_frame_clken = sync_dly[0];
  assign vid.post_img_red     = vid.post_frame_href ? red_q   : 8'd0;
  assign vid.post_img_green   = vid.post_frame_href ? green_q : 8'd0;
  assign vid.post_img_blue    = vid.post_frame_href ? blue_q  : 8'd0;

  logic        vsync_q, href_q, armed_q, size_err_q;
  logic [11:0] pix_cnt_q, line_cnt_q;
  logic        href_fall, vsync_rise, line_bad, frame_bad;

  assign href_fall  = href_q & ~vid.per_frame_href;
  assign vsync_rise = vid.per_frame_vsync & ~vsync_q;
  assign line_bad   = href_fall & (pix_cnt_q != IMG_HDISP);
  assign frame_bad  = vsync_rise & (line_cnt_q != IMG_VDISP);

  // Nothing is flagged until the first vsync after reset arms the checker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      armed_q    <= 1'b0;
      size_err_q <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      vsync_q    <= vid.per_frame_vsync;
      href_q     <= vid.per_frame_href;
      size_err_q <= armed_q & (line_bad | frame_bad);
      if (vsync_rise) begin
        armed_q <= 1'b1;
      end
      if (href_fall) begin
        pix_cnt_q <= '0;
      end else if (vid.per_frame_href && vid.per_frame_clken && pix_cnt_q != 12'hFFF) begin
        pix_cnt_q <= pix_cnt_q + 12'd1;
      end
      if (vsync_rise) begin
        line_cnt_q <= '0;
      end else if (href_fall && line_cnt_q != 12'hFFF) begin
        line_cnt_q <= line_cnt_q + 12'd1;
      end
    end
  end

  assign vid.size_err = size_err_q;

endmodule

// File: tb/tb_image_ycbcr444_rgb888.sv
// Bench for image_ycbcr444_rgb888: table vectors, random pixels against an arithmetic
// model with a 3-deep input history, mid-line reset, and frame geometry windows.
module tb_image_ycbcr444_rgb888;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       ce;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } vin_t;

  typedef struct {
    logic [7:0] y, cb, cr, r, g, b;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_ycbcr444_rgb888_if vif ();

  image_ycbcr444_rgb888 #(
    .IMG_HDISP (12'd8),
    .IMG_VDISP (12'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vif)
  );

  int   checks = 0;
  int   errors = 0;
  int   err_pulses = 0;
  vin_t hist[$];
  vin_t idle = '0;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] clamp(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  // Straight from the conversion equations, integer arithmetic.
  task automatic ref_rgb(input vin_t e, output logic [7:0] r, output logic [7:0] g,
                         output logic [7:0] b);
    int yi, cbi, cri;
    yi  = int'(e.y);
    cbi = int'(e.cb) - 128;
    cri = int'(e.cr) - 128;
    r = clamp((256 * yi + 359 * cri + 128) >>> 8);
    g = clamp((256 * yi - 88 * cbi - 183 * cri + 128) >>> 8);
    b = clamp((256 * yi + 454 * cbi + 128) >>> 8);
    if (!e.hs) begin
      r = 8'd0;
      g = 8'd0;
      b = 8'd0;
    end
  endtask

  task automatic drive(input vin_t v);
    vif.per_frame_vsync = v.vs;
    vif.per_frame_href  = v.hs;
    vif.per_frame_clken = v.ce;
    vif.per_img_Y       = v.y;
    vif.per_img_Cb      = v.cb;
    vif.per_img_Cr      = v.cr;
  endtask

  task automatic step(input vin_t v);
    vin_t       e;
    logic [7:0] er, eg, eb;
    drive(v);
    hist.push_back(v);
    @(posedge clk);
    #1;
    e = hist[hist.size() - 3];
    ref_rgb(e, er, eg, eb);
    chk("pipe", {5'b0, vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken,
                 vif.post_img_red, vif.post_img_green, vif.post_img_blue},
        {5'b0, e.vs, e.hs, e.ce, er, eg, eb});
    if (vif.size_err) err_pulses++;
    while (hist.size() > 3) void'(hist.pop_front());
  endtask

  function automatic vin_t mk(input logic vs, input logic hs, input logic ce);
    vin_t v;
    v.vs = vs;
    v.hs = hs;
    v.ce = ce;
    v.y  = 8'($urandom_range(0, 255));
    v.cb = 8'($urandom_range(0, 255));
    v.cr = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic prefill();
    hist.delete();
    repeat (3) hist.push_back(idle);
  endtask

  task automatic send_line(input int len);
    int   beats;
    logic ce;
    beats = 0;
    while (beats < len) begin
      ce = ($urandom_range(0, 3) != 0);
      step(mk(1'b0, 1'b1, ce));
      if (ce) beats++;
    end
    repeat (3) step(idle);
  endtask

  task automatic send_frame(input int nlines, input int bad_idx, input int bad_len);
    repeat (2) step(mk(1'b1, 1'b0, 1'b0));
    repeat (2) step(idle);
    for (int l = 0; l < nlines; l++) begin
      send_line((l == bad_idx) ? bad_len : 8);
    end
  endtask

  initial begin
    vecs[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    vecs[1] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
    vecs[2] = '{8'd0,   8'd0,   8'd128, 8'd0,   8'd44,  8'd0};
    vecs[3] = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0};
    vecs[4] = '{8'd255, 8'd255, 8'd0,   8'd76,  8'd255, 8'd255};
    vecs[5] = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd48,  8'd225};

    drive(idle);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {19'b0, vif.post_frame_vsync, vif.post_frame_href,
                          vif.post_frame_clken, vif.post_img_red, vif.post_img_green,
                          vif.post_img_blue, vif.size_err}, 32'd0);
    rst = 1'b0;
    prefill();

    // Single-beat table vectors, result visible exactly 3 clocks later.
    for (int i = 0; i < 6; i++) begin
      vin_t v;
      v = '{vs: 1'b0, hs: 1'b1, ce: 1'b1, y: vecs[i].y, cb: vecs[i].cb, cr: vecs[i].cr};
      step(v);
      step(idle);
      step(idle);
      chk($sformatf("vec%0d", i), {8'b0, vif.post_img_red, vif.post_img_green,
                                   vif.post_img_blue},
          {8'b0, vecs[i].r, vecs[i].g, vecs[i].b});
    end

    for (int i = 0; i < 300; i++) begin
      step(mk(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
    end
    chk("no_err_unarmed", err_pulses, 0);

    // Reset in the middle of a line clears every output immediately.
    for (int i = 0; i < 5; i++) step(mk(1'b0, 1'b1, 1'b1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid", {19'b0, vif.post_frame_vsync, vif.post_frame_href,
                    vif.post_frame_clken, vif.post_img_red, vif.post_img_green,
                    vif.post_img_blue, vif.size_err}, 32'd0);
    @(posedge clk);
    #1 drive(idle);
    #2 rst = 1'b0;
    prefill();
    repeat (4) step(idle);
    for (int i = 0; i < 20; i++) step(mk(1'b0, 1'b1, 1'b1));
    repeat (3) step(idle);

    err_pulses = 0;
    send_line(5);
    send_line(3);
    send_frame(4, -1, 0);
    send_frame(4, -1, 0);
    send_frame(4, -1, 0);
    chk("geom_good_frames", err_pulses, 0);

    err_pulses = 0;
    send_frame(4, 1, 7);
    send_frame(4, -1, 0);
    chk("geom_short_line", err_pulses, 1);

    err_pulses = 0;
    send_frame(3, -1, 0);
    send_frame(4, -1, 0);
    chk("geom_short_frame", err_pulses, 1);

    err_pulses = 0;
    send_frame(4, -1, 0);
    send_frame(4, -1, 0);
    chk("geom_recovered", err_pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
